// File: rtl/sys_array_tile_dispatch_if.sv
// Handshake and table-port bundle between the tile dispatcher and its environment.
// slave is the dispatcher's view; master is the splitter/array-controller side.
interface sys_array_tile_dispatch_if;
    logic        start;
    logic        tbl_ready;
    logic [15:0] tbl_last;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic [63:0] rd_o;
    logic [15:0] rd_to_n1;
    logic        tile_valid;
    logic        tile_ready;
    logic [63:0] tile_a;
    logic [63:0] tile_b;
    logic [63:0] tile_o;
    logic [15:0] tile_idx;
    logic [15:0] tile_count;
    logic        done;
    logic        err_oversize;

    modport slave (
        input  start, tbl_ready, tbl_last, rd_a, rd_b, rd_o, rd_to_n1, tile_ready,
        output rd_en, rd_addr, tile_valid, tile_a, tile_b, tile_o, tile_idx, tile_count,
               done, err_oversize
    );

    modport master (
        output start, tbl_ready, tbl_last, rd_a, rd_b, rd_o, rd_to_n1, tile_ready,
        input  rd_en, rd_addr, tile_valid, tile_a, tile_b, tile_o, tile_idx, tile_count,
               done, err_oversize
    );
endinterface

// File: rtl/sys_array_tile_dispatch.sv
// Scans the splitter node table and issues one tile command per leaf node.
// Define TILE_DISPATCH_FIT_CHECK_EN to skip leaves larger than the array and flag err_oversize.
module sys_array_tile_dispatch #(
    parameter int ARRAY_W  = 10,
    parameter int ARRAY_L  = 10,
    parameter int OUT_SIZE = 100
) (
    input logic                      clk,
    input logic                      reset_n,
    sys_array_tile_dispatch_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_TBL, READ, EVAL, ISSUE, DONE} state_e;

    state_e      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] n_q, n_d;
    logic        rd_en_q, rd_en_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        tile_valid_q, tile_valid_d;
    logic [63:0] tile_a_q, tile_a_d;
    logic [63:0] tile_b_q, tile_b_d;
    logic [63:0] tile_o_q, tile_o_d;
    logic [15:0] tile_idx_q, tile_idx_d;
    logic [15:0] tile_count_q, tile_count_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [15:0] hb, wb;
    logic        leaf, oversize, dispatch, advance;

    // rd_b packs {B_W_0, B_L_0, B_W_1, B_L_1}
    assign hb       = bus.rd_b[31:16] - bus.rd_b[63:48] + 16'd1;
    assign wb       = bus.rd_b[15:0]  - bus.rd_b[47:32] + 16'd1;
    assign leaf     = (bus.rd_to_n1 == 16'd0);
    assign oversize = (hb > 16'(ARRAY_W)) || (wb > 16'(ARRAY_L));

`ifdef TILE_DISPATCH_FIT_CHECK_EN
    assign dispatch = leaf && !oversize;
`else
    logic unused_oversize;
    assign unused_oversize = oversize;
    assign dispatch        = leaf;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        tile_valid_d = tile_valid_q;
        tile_a_d     = tile_a_q;
        tile_b_d     = tile_b_q;
        tile_o_d     = tile_o_q;
        tile_idx_d   = tile_idx_q;
        tile_count_d = tile_count_q;
        done_d       = 1'b0;
        err_d        = err_q;
        advance      = 1'b0;

        case (state_q)
            IDLE: ;
            WAIT_TBL: begin
                if (bus.tbl_ready) begin
                    // clamp so rd_addr stays inside the table
                    n_d       = (bus.tbl_last > 16'(OUT_SIZE)) ? 16'(OUT_SIZE) : bus.tbl_last;
                    idx_d     = 16'd0;
                    rd_addr_d = 16'd0;
                    state_d   = (bus.tbl_last == 16'd0) ? DONE : READ;
                end
            end
            READ: state_d = EVAL;
            EVAL: begin
                if (dispatch) begin
                    tile_a_d     = bus.rd_a;
                    tile_b_d     = bus.rd_b;
                    tile_o_d     = bus.rd_o;
                    tile_idx_d   = idx_q;
                    tile_valid_d = 1'b1;
                    state_d      = ISSUE;
                end else begin
                    advance = 1'b1;
                end
`ifdef TILE_DISPATCH_FIT_CHECK_EN
                if (leaf && oversize) err_d = 1'b1;
`endif
            end
            ISSUE: begin
                if (bus.tile_ready) begin
                    tile_valid_d = 1'b0;
                    if (tile_count_q != 16'hFFFF) tile_count_d = tile_count_q + 16'd1;
                    advance = 1'b1;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (idx_q == n_q - 16'd1) begin
                state_d = DONE;
            end else begin
                idx_d     = idx_q + 16'd1;
                rd_addr_d = idx_q + 16'd1;
                state_d   = READ;
            end
        end

        // start aborts whatever is in flight, including a pending tile
        if (bus.start) begin
            state_d      = WAIT_TBL;
            idx_d        = 16'd0;
            tile_count_d = 16'd0;
            tile_valid_d = 1'b0;
            err_d        = 1'b0;
        end

        rd_en_d = (state_d == READ);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= 16'd0;
            n_q          <= 16'd0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= 16'd0;
            tile_valid_q <= 1'b0;
            tile_a_q     <= 64'd0;
            tile_b_q     <= 64'd0;
            tile_o_q     <= 64'd0;
            tile_idx_q   <= 16'd0;
            tile_count_q <= 16'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            tile_valid_q <= tile_valid_d;
            tile_a_q     <= tile_a_d;
            tile_b_q     <= tile_b_d;
            tile_o_q     <= tile_o_d;
            tile_idx_q   <= tile_idx_d;
            tile_count_q <= tile_count_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.rd_en        = rd_en_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.tile_valid   = tile_valid_q;
    assign bus.tile_a       = tile_a_q;
    assign bus.tile_b       = tile_b_q;
    assign bus.tile_o       = tile_o_q;
    assign bus.tile_idx     = tile_idx_q;
    assign bus.tile_count   = tile_count_q;
    assign bus.done         = done_q;
    assign bus.err_oversize = err_q;
endmodule

// File: tb/tb_sys_array_tile_dispatch.sv
// Scoreboard bench: node tables are loaded into a behavioural memory, the expected
// tile stream is derived from the leaf/size rules and checked by an independent monitor.
module tb_sys_array_tile_dispatch;
    localparam int AW = 10;
    localparam int AL = 10;
`ifdef TILE_DISPATCH_FIT_CHECK_EN
    localparam bit FIT = 1'b1;
`else
    localparam bit FIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sys_array_tile_dispatch_if bus();
    sys_array_tile_dispatch #(.ARRAY_W(AW), .ARRAY_L(AL), .OUT_SIZE(100)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct {
        logic [15:0] idx;
        logic [63:0] a, b, o;
    } tile_t;

    tile_t       exp_q[$];
    logic [63:0] mem_a[128];
    logic [63:0] mem_b[128];
    logic [63:0] mem_o[128];
    logic [15:0] mem_c[128];
    int tests = 0, fails = 0;
    int exp_cnt = 0, exp_tiles = 0, cur_n = 0, bp_left = 0;
    bit exp_err = 1'b0, rdy_rand = 1'b0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // table memory with one-cycle read latency
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_a     <= mem_a[bus.rd_addr[6:0]];
            bus.rd_b     <= mem_b[bus.rd_addr[6:0]];
            bus.rd_o     <= mem_o[bus.rd_addr[6:0]];
            bus.rd_to_n1 <= mem_c[bus.rd_addr[6:0]];
        end
    end

    // array controller: optional forced stall on a presented tile, else ready or random
    initial begin
        bus.tile_ready = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (bus.tile_valid && bp_left > 0) begin
                bus.tile_ready = 1'b0;
                bp_left--;
            end else begin
                bus.tile_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // monitor
    tile_t held;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.rd_en) chk("rd_addr_in_range", 64'(int'(bus.rd_addr) < cur_n), 64'd1);
            chk("tile_count", 64'(bus.tile_count), 64'(exp_cnt));
            if (stalled) begin
                chk("stall_valid", 64'(bus.tile_valid), 64'd1);
                chk("stall_idx", 64'(bus.tile_idx), 64'(held.idx));
                chk("stall_b", bus.tile_b, held.b);
            end
            if (bus.start) begin
                exp_q.delete();
                exp_cnt = 0;
                stalled = 1'b0;
            end else if (bus.tile_valid && bus.tile_ready) begin
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_tile", 64'(bus.tile_idx), 64'hFFFF);
                end else begin
                    tile_t e;
                    e = exp_q.pop_front();
                    chk("tile_idx", 64'(bus.tile_idx), 64'(e.idx));
                    chk("tile_a", bus.tile_a, e.a);
                    chk("tile_b", bus.tile_b, e.b);
                    chk("tile_o", bus.tile_o, e.o);
                end
                if (exp_cnt < 65535) exp_cnt++;
            end else if (bus.tile_valid) begin
                stalled  = 1'b1;
                held.idx = bus.tile_idx;
                held.a   = bus.tile_a;
                held.b   = bus.tile_b;
                held.o   = bus.tile_o;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic set_node(input int i, input logic [15:0] bw0, bl0, bw1, bl1, input logic [15:0] child);
        mem_a[7'(i)] = {$urandom, $urandom};
        mem_b[7'(i)] = {bw0, bl0, bw1, bl1};
        mem_o[7'(i)] = {$urandom, $urandom};
        mem_c[7'(i)] = child;
    endtask

    // reference: every leaf is a tile unless the fit check rejects it
    task automatic push_expected(input int n);
        exp_tiles = 0;
        exp_err   = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [15:0] h, w;
            tile_t t;
            if (mem_c[7'(i)] != 16'd0) continue;
            h = mem_b[7'(i)][31:16] - mem_b[7'(i)][63:48] + 16'd1;
            w = mem_b[7'(i)][15:0] - mem_b[7'(i)][47:32] + 16'd1;
            if (FIT && (int'(h) > AW || int'(w) > AL)) begin
                exp_err = 1'b1;
                continue;
            end
            t.idx = 16'(i);
            t.a   = mem_a[7'(i)];
            t.b   = mem_b[7'(i)];
            t.o   = mem_o[7'(i)];
            exp_q.push_back(t);
            exp_tiles++;
        end
    endtask

    task automatic wait_done(input string nm);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        chk({nm, "_done"}, 64'(bus.done), 64'd1);
        chk({nm, "_count"}, 64'(bus.tile_count), 64'(exp_tiles));
        chk({nm, "_err"}, 64'(bus.err_oversize), 64'(exp_err));
        chk({nm, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk({nm, "_done_held"}, 64'(bus.done), 64'd1);
        chk({nm, "_valid_idle"}, 64'(bus.tile_valid), 64'd0);
    endtask

    task automatic run_scan(input string nm, input int n, input int bp, input bit rnd);
        @(posedge clk);
        #2;
        cur_n         = n;
        rdy_rand      = rnd;
        bp_left       = bp;
        bus.tbl_last  = 16'(n);
        bus.tbl_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        push_expected(n);
        @(posedge clk);
        #2;
        bus.tbl_ready = 1'b0;
        wait_done(nm);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.tbl_ready = 1'b0;
        bus.tbl_last  = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
        chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("rst_valid", 64'(bus.tile_valid), 64'd0);
        chk("rst_tile_a", bus.tile_a, 64'd0);
        chk("rst_tile_b", bus.tile_b, 64'd0);
        chk("rst_tile_o", bus.tile_o, 64'd0);
        chk("rst_tile_idx", 64'(bus.tile_idx), 64'd0);
        chk("rst_count", 64'(bus.tile_count), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err", 64'(bus.err_oversize), 64'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_done", 64'(bus.done), 64'd0);

        set_node(0, 16'd0, 16'd0, 16'd7, 16'd7, 16'd0);
        run_scan("single", 1, 0, 1'b0);

        set_node(0, 16'd0, 16'd0, 16'd9, 16'd9, 16'd1);
        set_node(1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd0);
        set_node(2, 16'd4, 16'd0, 16'd13, 16'd9, 16'd0);
        run_scan("three", 3, 0, 1'b0);

        set_node(0, 16'd1, 16'd1, 16'd4, 16'd4, 16'd0);
        set_node(1, 16'd0, 16'd0, 16'd2, 16'd2, 16'd0);
        run_scan("backpressure", 2, 5, 1'b0);

        set_node(0, 16'd0, 16'd0, 16'd11, 16'd3, 16'd0);
        run_scan("oversize", 1, 0, 1'b0);

        // start while a tile is pending
        set_node(0, 16'd0, 16'd0, 16'd3, 16'd3, 16'd0);
        set_node(1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0);
        @(posedge clk);
        #2;
        cur_n = 2; rdy_rand = 1'b0; bp_left = 1000;
        bus.tbl_last = 16'd2; bus.tbl_ready = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        push_expected(2);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.tile_valid) break;
        end
        chk("abort_valid_seen", 64'(bus.tile_valid), 64'd1);
        @(posedge clk);
        #2;
        bus.start = 1'b1; bus.tbl_ready = 1'b0;
        @(posedge clk);
        #2;
        bus.start = 1'b0; bp_left = 0;
        @(negedge clk);
        chk("abort_valid", 64'(bus.tile_valid), 64'd0);
        chk("abort_count", 64'(bus.tile_count), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_wait_tbl", 64'(bus.rd_en), 64'd0);
        push_expected(2);
        @(posedge clk);
        #2;
        bus.tbl_ready = 1'b1;
        wait_done("abort_restart");

        // empty table
        @(posedge clk);
        #2;
        cur_n = 0; bus.tbl_last = 16'd0; bus.tbl_ready = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        exp_tiles = 0; exp_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("empty_done", 64'(bus.done), 64'd1);
        chk("empty_count", 64'(bus.tile_count), 64'd0);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                logic [15:0] bw0, bl0;
                bw0 = 16'($urandom_range(0, 20));
                bl0 = 16'($urandom_range(0, 20));
                set_node(i, bw0, bl0, bw0 + 16'($urandom_range(0, 11)), bl0 + 16'($urandom_range(0, 11)),
                         ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 50)) : 16'd0);
            end
            run_scan($sformatf("rand%0d", r), n, int'($urandom_range(0, 3)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
